// File: rtl/decode_ibuf_fwd.sv
// -----------------------------------------------------------------------------
// decode_ibuf_fwd
//
// Decode front end sitting between fetch and execute.
//   * Fetched entries (PC, instruction, fetch exception) are buffered in a
//     DEPTH-entry in-order queue.
//   * The head entry's rs/rt operands are read from the regfile and can be
//     overridden by NFWD forwarding channels. Channel 0 is the youngest
//     pipeline stage and has the highest priority.
//   * The head is issued into a registered valid/ready output slot. The
//     branch and jump targets are computed while the entry is issued.
//
// Ports
//   clk, resetn                       clock, asynchronous active-low reset
//   in_valid_i / in_ready_o           fetch handshake
//   in_pc_i, in_inst_i,
//   in_exc_i, in_exccode_i            fetched entry
//   flush_i                           drops the queue and the output slot
//   rf_raddr1_o / rf_raddr2_o         head rs / rt (0 when the queue is empty)
//   rf_rdata1_i / rf_rdata2_i         regfile read data
//   fwd_addr_i / fwd_data_i /
//   fwd_ok_i                          packed forwarding channels, 5/32/1 bits each
//   out_valid_o / out_ready_i         issue-slot handshake
//   out_pc_o, out_inst_o,
//   out_rdata1_o, out_rdata2_o,
//   out_pc_b_o, out_pc_j_o,
//   out_exc_o, out_exccode_o          issued entry
//   perf_stall_o                      saturating count of forwarding-stall cycles
// -----------------------------------------------------------------------------
module decode_ibuf_fwd #(
  parameter int DEPTH = 4,
  parameter int NFWD  = 2
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         in_pc_i,
  input  logic [31:0]         in_inst_i,
  input  logic                in_exc_i,
  input  logic [4:0]          in_exccode_i,

  input  logic                flush_i,

  output logic [4:0]          rf_raddr1_o,
  output logic [4:0]          rf_raddr2_o,
  input  logic [31:0]         rf_rdata1_i,
  input  logic [31:0]         rf_rdata2_i,

  input  logic [5*NFWD-1:0]   fwd_addr_i,
  input  logic [32*NFWD-1:0]  fwd_data_i,
  input  logic [NFWD-1:0]     fwd_ok_i,

  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_pc_o,
  output logic [31:0]         out_inst_o,
  output logic [31:0]         out_rdata1_o,
  output logic [31:0]         out_rdata2_o,
  output logic [31:0]         out_pc_b_o,
  output logic [31:0]         out_pc_j_o,
  output logic                out_exc_o,
  output logic [4:0]          out_exccode_o,

  output logic [31:0]         perf_stall_o
);

  // Pointers carry one extra wrap bit. This lets "full" and "empty" be told
  // apart when the two pointers address the same slot.
  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  localparam ptr_t FULL_COUNT = ptr_t'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [4:0]  exccode;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Queue state
  // ---------------------------------------------------------------------------
  entry_t mem [DEPTH];
  ptr_t   wr_ptr;
  ptr_t   rd_ptr;
  ptr_t   count;

  entry_t head;
  logic   head_valid;
  logic   push;
  logic   issue;

  assign count      = wr_ptr - rd_ptr;
  assign in_ready_o = (count != FULL_COUNT);
  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr[AW-1:0]];

  // A refused push stays refused even when a pop happens in the same cycle.
  // Using the registered count keeps in_ready_o free of any path from out_ready_i.
  assign push = in_valid_i && in_ready_o && !flush_i;

  // ---------------------------------------------------------------------------
  // Operand read and forwarding
  // ---------------------------------------------------------------------------
  assign rf_raddr1_o = head_valid ? head.inst[25:21] : 5'd0;
  assign rf_raddr2_o = head_valid ? head.inst[20:16] : 5'd0;

  // Returns {ok, data} for one read port. The channel scan runs from the
  // lowest priority to the highest, so the youngest hitting channel is written
  // last and wins. Register 0 never hits, which also covers the fwd_addr == 0
  // "no write" encoding.
  function automatic logic [32:0] fwd_pick(
    input logic [4:0]         raddr,
    input logic [31:0]        rf_data,
    input logic [5*NFWD-1:0]  addrs,
    input logic [32*NFWD-1:0] datas,
    input logic [NFWD-1:0]    oks
  );
    logic [32:0] pick;
    pick = {1'b1, rf_data};
    for (int k = NFWD - 1; k >= 0; k--) begin
      if ((raddr != 5'd0) && (raddr == addrs[k*5 +: 5])) begin
        pick = {oks[k], datas[k*32 +: 32]};
      end
    end
    return pick;
  endfunction

  logic [31:0] op1_data;
  logic [31:0] op2_data;
  logic        op1_ok;
  logic        op2_ok;
  logic        stall;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here by the function's default). Otherwise a latch is inferred.
  always_comb begin
    {op1_ok, op1_data} = fwd_pick(rf_raddr1_o, rf_rdata1_i, fwd_addr_i, fwd_data_i, fwd_ok_i);
    {op2_ok, op2_data} = fwd_pick(rf_raddr2_o, rf_rdata2_i, fwd_addr_i, fwd_data_i, fwd_ok_i);
  end

  // Only the selected channel's ok flag matters. An older channel that also
  // hits but has not produced its result yet is shadowed and never stalls.
  assign stall = !op1_ok || !op2_ok;

  // An excepting entry never executes, so its operands do not matter and it
  // does not wait for them.
  assign issue = head_valid && (!stall || head.exc) &&
                 (!out_valid_o || out_ready_i) && !flush_i;

  // ---------------------------------------------------------------------------
  // Branch / jump targets (32-bit modular arithmetic)
  // ---------------------------------------------------------------------------
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] pc_b;
  logic [31:0] pc_j;

  assign pc_plus4  = head.pc + 32'd4;
  assign br_offset = {{14{head.inst[15]}}, head.inst[15:0], 2'b00};
  assign pc_b      = pc_plus4 + br_offset;
  assign pc_j      = {pc_plus4[31:28], head.inst[25:0], 2'b00};

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // NOTE: the entry array has no reset. An entry is only ever read after it
  // has been written, because the pointers decide which entries are valid.
  // Resetting the pointers is therefore enough to discard everything.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{pc: in_pc_i, inst: in_inst_i,
                               exc: in_exc_i, exccode: in_exccode_i};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ptr_t'(1);
      if (issue) rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_o   <= 1'b0;
      out_pc_o      <= '0;
      out_inst_o    <= '0;
      out_rdata1_o  <= '0;
      out_rdata2_o  <= '0;
      out_pc_b_o    <= '0;
      out_pc_j_o    <= '0;
      out_exc_o     <= 1'b0;
      out_exccode_o <= '0;
    end else if (flush_i) begin
      // Flush wins over a simultaneous out_ready_i. The data fields hold.
      out_valid_o <= 1'b0;
    end else if (issue) begin
      out_valid_o   <= 1'b1;
      out_pc_o      <= head.pc;
      out_inst_o    <= head.inst;
      out_rdata1_o  <= op1_data;
      out_rdata2_o  <= op2_data;
      out_pc_b_o    <= pc_b;
      out_pc_j_o    <= pc_j;
      out_exc_o     <= head.exc;
      out_exccode_o <= head.exccode;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter: saturates, and is not cleared by flush
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_o <= '0;
    end else if (head_valid && stall && !head.exc && !flush_i &&
                 (perf_stall_o != 32'hFFFF_FFFF)) begin
      perf_stall_o <= perf_stall_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_decode_ibuf_fwd.sv
// -----------------------------------------------------------------------------
// tb_decode_ibuf_fwd
//
// Directed bench for decode_ibuf_fwd. Each accepted push queues its expected
// issued result in a scoreboard. A monitor pops the scoreboard whenever the
// output slot is consumed and compares every field.
// -----------------------------------------------------------------------------
module tb_decode_ibuf_fwd;

  localparam int DEPTH = 4;
  localparam int NFWD  = 2;

  logic                clk;
  logic                resetn;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [31:0]         in_pc_i;
  logic [31:0]         in_inst_i;
  logic                in_exc_i;
  logic [4:0]          in_exccode_i;
  logic                flush_i;
  logic [4:0]          rf_raddr1_o;
  logic [4:0]          rf_raddr2_o;
  logic [31:0]         rf_rdata1_i;
  logic [31:0]         rf_rdata2_i;
  logic [5*NFWD-1:0]   fwd_addr_i;
  logic [32*NFWD-1:0]  fwd_data_i;
  logic [NFWD-1:0]     fwd_ok_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [31:0]         out_pc_o;
  logic [31:0]         out_inst_o;
  logic [31:0]         out_rdata1_o;
  logic [31:0]         out_rdata2_o;
  logic [31:0]         out_pc_b_o;
  logic [31:0]         out_pc_j_o;
  logic                out_exc_o;
  logic [4:0]          out_exccode_o;
  logic [31:0]         perf_stall_o;

  decode_ibuf_fwd #(.DEPTH(DEPTH), .NFWD(NFWD)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_pc_i       (in_pc_i),
    .in_inst_i     (in_inst_i),
    .in_exc_i      (in_exc_i),
    .in_exccode_i  (in_exccode_i),
    .flush_i       (flush_i),
    .rf_raddr1_o   (rf_raddr1_o),
    .rf_raddr2_o   (rf_raddr2_o),
    .rf_rdata1_i   (rf_rdata1_i),
    .rf_rdata2_i   (rf_rdata2_i),
    .fwd_addr_i    (fwd_addr_i),
    .fwd_data_i    (fwd_data_i),
    .fwd_ok_i      (fwd_ok_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_pc_o      (out_pc_o),
    .out_inst_o    (out_inst_o),
    .out_rdata1_o  (out_rdata1_o),
    .out_rdata2_o  (out_rdata2_o),
    .out_pc_b_o    (out_pc_b_o),
    .out_pc_j_o    (out_pc_j_o),
    .out_exc_o     (out_exc_o),
    .out_exccode_o (out_exccode_o),
    .perf_stall_o  (perf_stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Regfile model: register 0 reads 0, register r reads 0xC0DE_00rr.
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'hC0DE_0000 | {27'd0, a});
  endfunction

  assign rf_rdata1_i = rf_val(rf_raddr1_o);
  assign rf_rdata2_i = rf_val(rf_raddr2_o);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        exc;
    logic [4:0]  code;
  } exp_t;

  exp_t        sb[$];
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          issue_cnt = 0;
  int          accepted  = 0;
  logic [31:0] exp_perf  = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  task automatic set_fwd(input int k, input logic [4:0] a, input logic [31:0] d, input logic ok);
    fwd_addr_i[k*5 +: 5]   = a;
    fwd_data_i[k*32 +: 32] = d;
    fwd_ok_i[k]            = ok;
  endtask

  // Presents one entry for a single edge. It is recorded as expected only if
  // the DUT can take it at that edge.
  task automatic push_entry(input logic [31:0] pc, input logic [31:0] inst,
                            input logic exc, input logic [4:0] code,
                            input logic [31:0] rd1, input logic [31:0] rd2);
    exp_t e;
    in_valid_i   = 1'b1;
    in_pc_i      = pc;
    in_inst_i    = inst;
    in_exc_i     = exc;
    in_exccode_i = code;
    if (in_ready_o && !flush_i) begin
      e.pc   = pc;
      e.inst = inst;
      e.rd1  = rd1;
      e.rd2  = rd2;
      e.exc  = exc;
      e.code = code;
      sb.push_back(e);
      accepted++;
    end
    step();
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_issues(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (issue_cnt < target && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(issue_cnt), 32'(target));
  endtask

  // Scoreboard monitor: the slot is consumed at the next edge when valid and
  // ready are both high and no flush is pending.
  initial begin
    exp_t        e;
    logic [31:0] pc4;
    forever begin
      @(negedge clk);
      if (resetn && out_valid_o && out_ready_i && !flush_i) begin
        issue_cnt++;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e   = sb.pop_front();
          pc4 = e.pc + 32'd4;
          check("out_pc",      out_pc_o,      e.pc);
          check("out_inst",    out_inst_o,    e.inst);
          check("out_rdata1",  out_rdata1_o,  e.rd1);
          check("out_rdata2",  out_rdata2_o,  e.rd2);
          check("out_exc",     32'(out_exc_o),     32'(e.exc));
          check("out_exccode", 32'(out_exccode_o), 32'(e.code));
          check("out_pc_b", out_pc_b_o,
                pc4 + {{14{e.inst[15]}}, e.inst[15:0], 2'b00});
          check("out_pc_j", out_pc_j_o, {pc4[31:28], e.inst[25:0], 2'b00});
        end
      end
    end
  end

  initial begin
    int          base;
    logic [31:0] pc;
    logic [15:0] imm;

    resetn       = 1'b0;
    in_valid_i   = 1'b0;
    in_pc_i      = '0;
    in_inst_i    = '0;
    in_exc_i     = 1'b0;
    in_exccode_i = '0;
    flush_i      = 1'b0;
    out_ready_i  = 1'b0;
    fwd_addr_i   = '0;
    fwd_data_i   = '0;
    fwd_ok_i     = '0;

    // ---------------- Reset state ----------------
    step();
    step();
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_pc",    out_pc_o,         32'd0);
    check("rst_perf",      perf_stall_o,     32'd0);
    check("rst_raddr1",    32'(rf_raddr1_o), 32'd0);
    resetn = 1'b1;
    step();
    check("rst_in_ready",  32'(in_ready_o),  32'd1);

    // ---------------- Stream: 8 back-to-back, no hits ----------------
    out_ready_i = 1'b1;
    base = issue_cnt;
    for (int i = 0; i < 8; i++) begin
      pc  = 32'h0040_0000 + 32'(i) * 32'd4;
      imm = 16'($urandom);
      if (i == 6) imm = 16'h8000;
      if (i == 7) begin
        pc  = 32'hFFFF_FFFC;
        imm = 16'h0010;
      end
      push_entry(pc, mk_inst(5'(i + 1), 5'(i + 9), imm), 1'b0, 5'd0,
                 rf_val(5'(i + 1)), rf_val(5'(i + 9)));
      check("stream_valid", 32'(out_valid_o), (i >= 1) ? 32'd1 : 32'd0);
    end
    idle();
    step();
    check("stream_last_valid", 32'(out_valid_o), 32'd1);
    step();
    check("stream_drained", 32'(out_valid_o), 32'd0);
    check("stream_issues", 32'(issue_cnt - base), 32'd8);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // ---------------- Full: hold downstream, push DEPTH+2 ----------------
    // The first entry moves into the empty output slot, so DEPTH+1 are accepted.
    out_ready_i = 1'b0;
    accepted = 0;
    base = issue_cnt;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push_entry(32'h0001_0000 + 32'(i) * 32'd4, mk_inst(5'(i + 2), 5'(i + 20), 16'(i)),
                 1'b0, 5'd0, rf_val(5'(i + 2)), rf_val(5'(i + 20)));
    end
    check("full_in_ready", 32'(in_ready_o), 32'd0);
    check("full_accepted", 32'(accepted), 32'(DEPTH + 1));
    // Release downstream while still offering an entry: the pop does not open
    // room for a push in that same cycle.
    out_ready_i = 1'b1;
    push_entry(32'h0BAD_0000, mk_inst(5'd1, 5'd1, 16'd0), 1'b0, 5'd0, 32'd0, 32'd0);
    check("full_refused", 32'(accepted), 32'(DEPTH + 1));
    idle();
    wait_issues("full_drain", base + DEPTH + 1, 20);
    step();
    step();
    check("full_exact", 32'(issue_cnt - base), 32'(DEPTH + 1));
    check("full_sb_empty", 32'(sb.size()), 32'd0);

    // ---------------- Priority: channel 0 beats channel 1 ----------------
    base = issue_cnt;
    set_fwd(0, 5'd5, 32'h0000_000A, 1'b1);
    set_fwd(1, 5'd5, 32'h0000_000B, 1'b0);   // shadowed: must not stall
    push_entry(32'h0002_0000, mk_inst(5'd5, 5'd7, 16'h0004), 1'b0, 5'd0,
               32'h0000_000A, rf_val(5'd7));
    idle();
    wait_issues("prio_issue", base + 1, 10);
    check("prio_no_stall", perf_stall_o, exp_perf);

    // Channel 0 not ready -> stall, counter runs, nothing issues.
    base = issue_cnt;
    set_fwd(0, 5'd5, 32'h0000_000A, 1'b0);
    set_fwd(1, 5'd5, 32'h0000_000B, 1'b1);
    push_entry(32'h0002_0010, mk_inst(5'd5, 5'd7, 16'h0008), 1'b0, 5'd0,
               32'h0000_000A, rf_val(5'd7));
    idle();
    for (int i = 0; i < 4; i++) step();
    exp_perf = exp_perf + 32'd4;
    check("stall_no_issue", 32'(out_valid_o), 32'd0);
    check("stall_perf",     perf_stall_o,     exp_perf);
    set_fwd(0, 5'd5, 32'h0000_000A, 1'b1);
    wait_issues("stall_release", base + 1, 10);
    check("stall_perf_hold", perf_stall_o, exp_perf);

    // rt hits only channel 1, which is not ready: the second port also stalls.
    base = issue_cnt;
    set_fwd(0, 5'd3, 32'h0000_0033, 1'b1);
    set_fwd(1, 5'd7, 32'h0000_000B, 1'b0);
    push_entry(32'h0002_0020, mk_inst(5'd5, 5'd7, 16'hFFFF), 1'b0, 5'd0,
               rf_val(5'd5), 32'h0000_000B);
    idle();
    step();
    step();
    exp_perf = exp_perf + 32'd2;
    check("rt_stall_perf", perf_stall_o, exp_perf);
    set_fwd(1, 5'd7, 32'h0000_000B, 1'b1);
    wait_issues("rt_release", base + 1, 10);

    // ---------------- Exception ignores stall ----------------
    base = issue_cnt;
    set_fwd(0, 5'd9, 32'h0000_00DD, 1'b0);
    set_fwd(1, 5'd0, 32'h0000_0000, 1'b0);
    push_entry(32'h0003_0000, mk_inst(5'd9, 5'd0, 16'h0001), 1'b1, 5'd4,
               32'h0000_00DD, 32'd0);
    idle();
    check("exc_lat0", 32'(out_valid_o), 32'd0);
    step();
    check("exc_valid",   32'(out_valid_o),   32'd1);
    check("exc_flag",    32'(out_exc_o),     32'd1);
    check("exc_code",    32'(out_exccode_o), 32'd4);
    check("exc_no_perf", perf_stall_o,       exp_perf);
    wait_issues("exc_issue", base + 1, 10);

    // rs = rt = 0 with fwd_addr = 0 on a non-ready channel: no hit, no stall.
    base = issue_cnt;
    set_fwd(0, 5'd0, 32'h0000_00DD, 1'b0);
    push_entry(32'h0003_0010, mk_inst(5'd0, 5'd0, 16'h0002), 1'b0, 5'd0, 32'd0, 32'd0);
    idle();
    step();
    check("zero_valid", 32'(out_valid_o), 32'd1);
    wait_issues("zero_issue", base + 1, 10);
    check("zero_no_perf", perf_stall_o, exp_perf);

    // ---------------- Flush with a simultaneous push ----------------
    set_fwd(0, 5'd0, 32'd0, 1'b1);
    set_fwd(1, 5'd0, 32'd0, 1'b1);
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_entry(32'h0004_0000 + 32'(i) * 32'd4, mk_inst(5'(i + 1), 5'(i + 1), 16'd0),
                 1'b0, 5'd0, rf_val(5'(i + 1)), rf_val(5'(i + 1)));
    end
    check("flush_pre_valid", 32'(out_valid_o), 32'd1);
    flush_i = 1'b1;
    push_entry(32'h0F0F_0000, mk_inst(5'd6, 5'd6, 16'd0), 1'b0, 5'd0, 32'd0, 32'd0);
    flush_i = 1'b0;
    idle();
    sb.delete();
    check("flush_valid",    32'(out_valid_o), 32'd0);
    check("flush_in_ready", 32'(in_ready_o),  32'd1);
    check("flush_empty",    32'(rf_raddr1_o), 32'd0);
    base = issue_cnt;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("flush_no_issue", 32'(issue_cnt - base), 32'd0);
    push_entry(32'h0004_0100, mk_inst(5'd12, 5'd13, 16'h0003), 1'b0, 5'd0,
               rf_val(5'd12), rf_val(5'd13));
    idle();
    wait_issues("flush_after", base + 1, 10);
    check("flush_perf_kept", perf_stall_o, exp_perf);

    // ---------------- Asynchronous reset mid-stream ----------------
    for (int i = 0; i < 3; i++) begin
      push_entry(32'h0005_0000 + 32'(i) * 32'd4, mk_inst(5'(i + 3), 5'(i + 4), 16'd5),
                 1'b0, 5'd0, rf_val(5'(i + 3)), rf_val(5'(i + 4)));
    end
    #2;
    resetn     = 1'b0;
    in_valid_i = 1'b0;
    #1;
    sb.delete();
    exp_perf = 32'd0;
    check("arst_valid",    32'(out_valid_o),   32'd0);
    check("arst_pc",       out_pc_o,           32'd0);
    check("arst_inst",     out_inst_o,         32'd0);
    check("arst_rdata1",   out_rdata1_o,       32'd0);
    check("arst_pc_b",     out_pc_b_o,         32'd0);
    check("arst_exccode",  32'(out_exccode_o), 32'd0);
    check("arst_perf",     perf_stall_o,       exp_perf);
    check("arst_raddr1",   32'(rf_raddr1_o),   32'd0);
    step();
    resetn = 1'b1;
    step();
    check("arst_in_ready", 32'(in_ready_o), 32'd1);
    base = issue_cnt;
    push_entry(32'h0006_0000, mk_inst(5'd17, 5'd18, 16'h0007), 1'b0, 5'd0,
               rf_val(5'd17), rf_val(5'd18));
    idle();
    wait_issues("arst_after", base + 1, 10);
    step();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
